// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: queues CPU pixel writes, drains them into the
// back-buffer SRAM whenever the display fetch does not own the memory, and
// performs front/back buffer swaps only during vertical blank once every
// queued write has landed.
//
// Handshake: a write is accepted on a rising Clock edge when WrValid and
// WrReady are both 1 in the cycle before it. WrReady does not depend on
// WrValid. MemWe is a one-cycle strobe with no back-pressure.
module fb_write_sched #(
   parameter int DEPTH = 4,
   parameter int AW    = 15,
   parameter int DW    = 8
) (
   input  logic          Clock,
   input  logic          Reset_n,
   input  logic          WrValid,
   input  logic [AW-1:0] WrAddr,
   input  logic [DW-1:0] WrData,
   output logic          WrReady,
   input  logic          SwapReq,
   input  logic          HBlank,
   input  logic          VBlank,
   input  logic [9:0]    Col,
   output logic          MemWe,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemData,
   output logic          MemBuf,
   output logic          BufSel,
   output logic          SwapPending,
   output logic          FrameTick,
   output logic [4:0]    Count
);

   localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] DEPTH_C = 5'(DEPTH);

   // Queue storage and pointers. Pointers wrap naturally because DEPTH is a
   // power of two.
   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [4:0]    count_q;

   logic          buf_sel_q;
   logic          pending_q;

   logic          fetch_block;
   logic          swap_exec;
   logic          ready;
   logic          push;
   logic          pop;

   // Only the two low column bits matter for the fetch slot.
   logic          unused_col;
   assign unused_col = ^Col[9:2];

   // Arbitration: fetch slot, swap window, push/pop decisions.
   always_comb begin
      fetch_block = ~HBlank & ~VBlank & (Col[1:0] == 2'b11);
      // A swap needs an empty queue and no write still on its way to SRAM.
      swap_exec   = pending_q & VBlank & (count_q == 5'd0) & ~MemWe;
      // Pushes are refused while full (no push-through) and in the swap
      // cycle, so every accepted write belongs entirely to one buffer.
      ready       = (count_q < DEPTH_C) & ~swap_exec;
      push        = WrValid & ready;
      pop         = (count_q != 5'd0) & ~fetch_block;
   end

   assign WrReady     = ready;
   assign Count       = count_q;
   assign BufSel      = buf_sel_q;
   assign SwapPending = pending_q;

   // Queue payload storage; contents are don't-care until written.
   always_ff @(posedge Clock) begin
      if (push) begin
         addr_mem[wr_ptr] <= WrAddr;
         data_mem[wr_ptr] <= WrData;
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= 5'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + 5'd1;
            2'b01:   count_q <= count_q - 5'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Registered SRAM write port; the target buffer is fixed at pop time.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         MemWe   <= 1'b0;
         MemAddr <= '0;
         MemData <= '0;
         MemBuf  <= 1'b1;
      end else begin
         MemWe <= pop;
         if (pop) begin
            MemAddr <= addr_mem[rd_ptr];
            MemData <= data_mem[rd_ptr];
            MemBuf  <= ~buf_sel_q;
         end
      end
   end

   // Swap request latch, front-buffer select and frame tick.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         buf_sel_q <= 1'b0;
         pending_q <= 1'b0;
         FrameTick <= 1'b0;
      end else begin
         FrameTick <= swap_exec;
         if (swap_exec) begin
            buf_sel_q <= ~buf_sel_q;
            // A request arriving in the swap cycle is kept for the next frame.
            pending_q <= SwapReq;
         end else if (SwapReq) begin
            pending_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fb_write_sched.sv
// Randomised bench for fb_write_sched with a queue-based reference model and
// an output scoreboard.
module tb_fb_write_sched;

   localparam int DEPTH = 4;
   localparam int AW    = 15;
   localparam int DW    = 8;
   localparam int EW    = AW + DW + 1;

   logic          Clock = 1'b0;
   logic          Reset_n = 1'b1;
   logic          WrValid = 1'b0;
   logic [AW-1:0] WrAddr = '0;
   logic [DW-1:0] WrData = '0;
   logic          WrReady;
   logic          SwapReq = 1'b0;
   logic          HBlank = 1'b0;
   logic          VBlank = 1'b0;
   logic [9:0]    Col = '0;
   logic          MemWe;
   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemData;
   logic          MemBuf;
   logic          BufSel;
   logic          SwapPending;
   logic          FrameTick;
   logic [4:0]    Count;

   int n_checks = 0;
   int n_fail   = 0;
   logic col_run = 1'b0;

   // Reference model state: pending writes, expected SRAM writes, buffers.
   logic [AW+DW-1:0] m_q[$];
   logic [EW-1:0]    exp_q[$];
   logic             m_we   = 1'b0;
   logic             m_buf  = 1'b0;
   logic             m_pend = 1'b0;
   logic             m_tick = 1'b0;
   logic             prev_fb = 1'b0;

   fb_write_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .WrValid(WrValid), .WrAddr(WrAddr),
      .WrData(WrData), .WrReady(WrReady), .SwapReq(SwapReq), .HBlank(HBlank),
      .VBlank(VBlank), .Col(Col), .MemWe(MemWe), .MemAddr(MemAddr),
      .MemData(MemData), .MemBuf(MemBuf), .BufSel(BufSel),
      .SwapPending(SwapPending), .FrameTick(FrameTick), .Count(Count)
   );

   // Clock generation.
   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_fb();
      return !HBlank && !VBlank && (Col[1:0] == 2'b11);
   endfunction

   function automatic logic model_swap();
      return m_pend && VBlank && (m_q.size() == 0) && !m_we;
   endfunction

   function automatic logic model_ready();
      return (m_q.size() < DEPTH) && !model_swap();
   endfunction

   // Reference model: advances one cycle per rising edge from the inputs.
   always @(posedge Clock) begin
      logic fb, sw, rdy;
      logic [AW+DW-1:0] e;
      if (!Reset_n) begin
         m_q.delete();
         exp_q.delete();
         m_we = 0; m_buf = 0; m_pend = 0; m_tick = 0; prev_fb = 0;
      end else begin
         fb  = model_fb();
         sw  = model_swap();
         rdy = model_ready();
         prev_fb = fb;
         m_tick  = sw;
         m_we    = 0;
         if (m_q.size() > 0 && !fb) begin
            e = m_q.pop_front();
            exp_q.push_back({e, ~m_buf});
            m_we = 1;
         end
         if (WrValid && rdy) m_q.push_back({WrAddr, WrData});
         if (sw) begin
            m_buf  = !m_buf;
            m_pend = SwapReq;
         end else if (SwapReq) begin
            m_pend = 1;
         end
      end
   end

   // Monitor: compares outputs mid-cycle and retires SRAM writes from the scoreboard.
   always @(negedge Clock) begin
      logic [EW-1:0] e;
      if (Reset_n) begin
         chk("wr_ready", WrReady, model_ready());
         chk("count", Count, m_q.size());
         chk("mem_we", MemWe, m_we);
         chk("buf_sel", BufSel, m_buf);
         chk("swap_pending", SwapPending, m_pend);
         chk("frame_tick", FrameTick, m_tick);
         if (MemWe) begin
            chk("we_after_fetch_slot", prev_fb, 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("mem_addr", MemAddr, e[EW-1:DW+1]);
               chk("mem_data", MemData, e[DW:1]);
               chk("mem_buf", MemBuf, e[0]);
            end
         end
      end
   end

   // Driver tasks.
   task automatic tick();
      @(posedge Clock);
      #2;
      if (col_run) Col = Col + 10'd1;
   endtask

   task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      WrValid = 1; WrAddr = a; WrData = d;
      tick();
      WrValid = 0;
   endtask

   task automatic pulse_swap();
      SwapReq = 1;
      tick();
      SwapReq = 0;
   endtask

   task automatic do_reset();
      Reset_n = 0;
      #1;
      chk("rst_count", Count, 0);
      chk("rst_wr_ready", WrReady, 1);
      chk("rst_mem_we", MemWe, 0);
      chk("rst_mem_addr", MemAddr, 0);
      chk("rst_mem_data", MemData, 0);
      chk("rst_mem_buf", MemBuf, 1);
      chk("rst_buf_sel", BufSel, 0);
      chk("rst_swap_pending", SwapPending, 0);
      chk("rst_frame_tick", FrameTick, 0);
      tick();
      tick();
      Reset_n = 1;
   endtask

   task automatic wait_bufsel(input logic v, input int budget);
      for (int i = 0; i < budget && BufSel !== v; i++) tick();
      chk("swap_wait_buf_sel", BufSel, v);
   endtask

   // Stimulus sequence.
   initial begin
      #1;
      do_reset();

      // Single write in vertical blank.
      VBlank = 1; HBlank = 0;
      drive_write(15'h1234, 8'hA5);
      repeat (4) tick();

      // Fill with the fetch slot held, then release.
      VBlank = 0; Col = 10'd3;
      for (int i = 0; i < 5; i++) drive_write(15'(16 + i), 8'(i + 1));
      #1;
      chk("fill_count", Count, 4);
      chk("fill_ready", WrReady, 0);
      Col = 10'd0;
      repeat (6) tick();

      // Full queue drained during active video with a running column.
      Col = 10'd3;
      for (int i = 0; i < 4; i++) drive_write(15'($urandom), 8'($urandom));
      col_run = 1;
      repeat (6) tick();
      #1;
      chk("interleave_drained", Count, 0);
      col_run = 0;

      // Deferred swap with two writes queued.
      Col = 10'd3;
      drive_write(15'h0100, 8'h11);
      drive_write(15'h0101, 8'h22);
      pulse_swap();
      VBlank = 1;
      wait_bufsel(1, 20);
      tick();
      chk("deferred_pending_clear", SwapPending, 0);

      // Missed window: queue kept busy through a blank.
      VBlank = 0; HBlank = 1;
      WrValid = 1;
      for (int i = 0; i < 3; i++) begin
         WrAddr = 15'($urandom); WrData = 8'($urandom); tick();
      end
      pulse_swap();
      VBlank = 1;
      for (int i = 0; i < 10; i++) begin
         WrAddr = 15'($urandom); WrData = 8'($urandom); tick();
      end
      VBlank = 0; WrValid = 0;
      repeat (6) tick();
      chk("missed_buf_sel", BufSel, 1);
      VBlank = 1;
      wait_bufsel(0, 20);

      // Reset mid-drain.
      VBlank = 0; HBlank = 0; Col = 10'd3;
      for (int i = 0; i < 3; i++) drive_write(15'($urandom), 8'($urandom));
      #1;
      chk("pre_reset_count", Count, 3);
      Col = 10'd0;
      tick();
      do_reset();
      repeat (5) tick();

      // Randomised phases.
      for (int ph = 0; ph < 40; ph++) begin
         int mode, len, p;
         mode = $urandom_range(0, 3);
         len  = $urandom_range(20, 80);
         p    = $urandom_range(10, 90);
         VBlank  = (mode == 0);
         HBlank  = (mode == 2);
         col_run = (mode == 1);
         if (mode == 3) begin
            Col = 10'd3;
            len = $urandom_range(3, 10);
         end
         for (int c = 0; c < len; c++) begin
            WrValid = ($urandom_range(0, 99) < p);
            WrAddr  = 15'($urandom);
            WrData  = 8'($urandom);
            SwapReq = ($urandom_range(0, 29) == 0);
            tick();
         end
         WrValid = 0; SwapReq = 0;
      end

      // Drain everything and settle.
      col_run = 0; VBlank = 1; HBlank = 0;
      repeat (20) tick();
      chk("final_scoreboard_empty", exp_q.size(), 0);
      chk("final_count", Count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
